// File: rtl/bram_port_arbiter_if.sv
// rtl/bram_port_arbiter_if.sv - requester-side bundle for one BRAM port A client
//
// Purpose: groups one requester's access bundle (request, write enable,
// address, write data) with its grant and read-return signals.
// Ports (signals):
//    req    - access request, held until granted
//    we     - 1 = write, 0 = read
//    addr   - BRAM word address
//    din    - write data
//    gnt    - grant; the access completes on the edge where req & gnt
//    dout   - read data returned to this requester
//    rvalid - dout valid for one cycle
// Modports: master = requester side, slave = arbiter side.

interface bram_port_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] din;
   logic              gnt;
   logic [DATA_W-1:0] dout;
   logic              rvalid;

   modport master (
      output req, we, addr, din,
      input  gnt, dout, rvalid
   );

   modport slave (
      input  req, we, addr, din,
      output gnt, dout, rvalid
   );
endinterface

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - CPU-priority arbiter for BRAM port A with bounded aux wait
//
// Purpose: shares BRAM port A between the CPU (priority) and an auxiliary
// master. The aux master is forced ahead of the CPU after MAX_WAIT denied
// cycles. Read data is steered back to whichever requester issued the read,
// one cycle later, with a single-cycle valid strobe.
// Ports:
//    clk       - system clock, rising edge
//    rst       - asynchronous active-low reset
//    cpu       - CPU requester bundle (slave side)
//    aux       - auxiliary requester bundle (slave side)
//    bram_addr - to BRAM addr_a
//    bram_din  - to BRAM data_a
//    bram_we   - to BRAM we_a
//    bram_q    - from BRAM q_a (registered, 1-cycle latency)

module bram_port_arbiter #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 16,
   parameter int MAX_WAIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   bram_port_arbiter_if.slave  cpu,
   bram_port_arbiter_if.slave  aux,
   output logic [ADDR_W-1:0]   bram_addr,
   output logic [DATA_W-1:0]   bram_din,
   output logic                bram_we,
   input  logic [DATA_W-1:0]   bram_q
);

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   logic [3:0] wait_cnt;
   logic [1:0] rd_owner;   // [1] = aux read in flight, [0] = cpu read in flight
   logic       force_aux;
   logic       cpu_gnt_i;
   logic       aux_gnt_i;

   // Grants are gated by rst so nothing can be issued while reset is held.
   always_comb begin
      force_aux = (wait_cnt == MAX_WAIT_C);
      aux_gnt_i = rst & aux.req & (force_aux | ~cpu.req);
      cpu_gnt_i = rst & cpu.req & ~aux_gnt_i;
   end

   assign cpu.gnt = cpu_gnt_i;
   assign aux.gnt = aux_gnt_i;

   always_comb begin
      bram_addr = '0;
      bram_din  = '0;
      bram_we   = 1'b0;
      if (aux_gnt_i) begin
         bram_addr = aux.addr;
         bram_din  = aux.din;
         bram_we   = aux.we;
      end else if (cpu_gnt_i) begin
         bram_addr = cpu.addr;
         bram_din  = cpu.din;
         bram_we   = cpu.we;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt <= 4'd0;
         rd_owner <= 2'b00;
      end else begin
         // Count only while aux is actually being denied; any gap clears it.
         if (aux.req && !aux_gnt_i) begin
            if (wait_cnt != MAX_WAIT_C)
               wait_cnt <= wait_cnt + 4'd1;
         end else begin
            wait_cnt <= 4'd0;
         end
         rd_owner <= {aux_gnt_i & ~aux.we, cpu_gnt_i & ~cpu.we};
      end
   end

   // BRAM q is shared; the owner bits say whose data it is this cycle.
   assign cpu.rvalid = rd_owner[0];
   assign aux.rvalid = rd_owner[1];
   assign cpu.dout   = bram_q;
   assign aux.dout   = bram_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - table-driven self-checking bench for bram_port_arbiter

module tb_bram_port_arbiter;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_din;
   logic              bram_we;
   logic [DATA_W-1:0] bram_q;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   int checks = 0;
   int errors = 0;

   bram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_if ();
   bram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) aux_if ();

   bram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu       (cpu_if.slave),
      .aux       (aux_if.slave),
      .bram_addr (bram_addr),
      .bram_din  (bram_din),
      .bram_we   (bram_we),
      .bram_q    (bram_q)
   );

   always #5 clk = ~clk;

   // Behavioural BRAM port A: registered read-first output.
   always @(posedge clk) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      bram_q <= mem[bram_addr];
   end

   typedef struct {
      logic              rst;
      logic              cr;
      logic              cw;
      logic [ADDR_W-1:0] ca;
      logic [DATA_W-1:0] cd;
      logic              ar;
      logic              aw;
      logic [ADDR_W-1:0] aa;
      logic [DATA_W-1:0] ad;
      logic              e_cg;
      logic              e_ag;
      logic              e_crv;
      logic              e_arv;
      logic              e_bwe;
      logic [DATA_W-1:0] e_q;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic cr, input logic cw, input logic [9:0] ca,
                      input logic [15:0] cd, input logic ar, input logic aw, input logic [9:0] aa,
                      input logic [15:0] ad, input logic cg, input logic ag, input logic crv,
                      input logic arv, input logic bwe, input logic [15:0] q);
      vec_t v;
      v.rst = r; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
      v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
      v.e_cg = cg; v.e_ag = ag; v.e_crv = crv; v.e_arv = arv; v.e_bwe = bwe; v.e_q = q;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic cr, input logic cw, input logic [9:0] ca, input logic [15:0] cd,
                        input logic ar, input logic aw, input logic [9:0] aa, input logic [15:0] ad);
      cpu_if.req = cr; cpu_if.we = cw; cpu_if.addr = ca; cpu_if.din = cd;
      aux_if.req = ar; aux_if.we = aw; aux_if.addr = aa; aux_if.din = ad;
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'h0000;
      mem[1] = 16'h1111;
      mem[2] = 16'h2222;
      drive(0, 0, 0, 0, 0, 0, 0, 0);

      //  rst cr cw ca      cd        ar aw aa      ad   cg ag crv arv bwe q
      add(0,  1, 1, 10'h012, 16'hBEEF, 1, 0, 10'h002, 0,  0, 0, 0,  0,  0,  0);       // reset hold
      add(1,  1, 1, 10'h012, 16'hBEEF, 0, 0, 10'h000, 0,  1, 0, 0,  0,  1,  0);       // write 0x012
      add(1,  1, 0, 10'h012, 16'h0000, 0, 0, 10'h000, 0,  1, 0, 0,  0,  0,  0);       // read 0x012
      add(1,  0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 0,  0, 0, 1,  0,  0,  16'hBEEF);
      add(1,  1, 0, 10'h001, 16'h0000, 0, 0, 10'h000, 0,  1, 0, 0,  0,  0,  0);       // cpu rd 1
      add(1,  0, 0, 10'h000, 16'h0000, 1, 0, 10'h002, 0,  0, 1, 1,  0,  0,  16'h1111); // aux rd 2
      add(1,  0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 0,  0, 0, 0,  1,  0,  16'h2222);
      // contention 4:1
      add(1,  1, 0, 10'h001, 0, 1, 0, 10'h002, 0,  1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++)
         add(1, 1, 0, 10'h001, 0, 1, 0, 10'h002, 0,  1, 0, 1, 0, 0, 16'h1111);
      add(1,  1, 0, 10'h001, 0, 1, 0, 10'h002, 0,  0, 1, 1, 0, 0, 16'h1111);
      add(1,  1, 0, 10'h001, 0, 1, 0, 10'h002, 0,  1, 0, 0, 1, 0, 16'h2222);
      for (int k = 0; k < 3; k++)
         add(1, 1, 0, 10'h001, 0, 1, 0, 10'h002, 0,  1, 0, 1, 0, 0, 16'h1111);
      add(1,  1, 0, 10'h001, 0, 1, 0, 10'h002, 0,  0, 1, 1, 0, 0, 16'h1111);
      add(1,  1, 0, 10'h001, 0, 1, 0, 10'h002, 0,  1, 0, 0, 1, 0, 16'h2222);
      // aux waits 2 cycles then drops; re-request must wait the full 4 again
      add(1,  1, 0, 10'h001, 0, 1, 0, 10'h002, 0,  1, 0, 1, 0, 0, 16'h1111);
      add(1,  1, 0, 10'h001, 0, 1, 0, 10'h002, 0,  1, 0, 1, 0, 0, 16'h1111);
      add(1,  1, 0, 10'h001, 0, 0, 0, 10'h002, 0,  1, 0, 1, 0, 0, 16'h1111);
      for (int k = 0; k < 4; k++)
         add(1, 1, 0, 10'h001, 0, 1, 0, 10'h002, 0,  1, 0, 1, 0, 0, 16'h1111);
      add(1,  1, 0, 10'h001, 0, 1, 0, 10'h002, 0,  0, 1, 1, 0, 0, 16'h1111);
      add(1,  0, 0, 10'h000, 0, 0, 0, 10'h000, 0,  0, 0, 0, 1, 0, 16'h2222);

      foreach (vecs[i]) begin
         logic [ADDR_W-1:0] e_addr;
         @(negedge clk);
         rst = vecs[i].rst;
         drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
               vecs[i].ar, vecs[i].aw, vecs[i].aa, vecs[i].ad);
         #2;
         e_addr = vecs[i].e_ag ? vecs[i].aa : (vecs[i].e_cg ? vecs[i].ca : '0);
         chk($sformatf("row%0d cpu_gnt", i), 32'(cpu_if.gnt), 32'(vecs[i].e_cg));
         chk($sformatf("row%0d aux_gnt", i), 32'(aux_if.gnt), 32'(vecs[i].e_ag));
         chk($sformatf("row%0d cpu_rvalid", i), 32'(cpu_if.rvalid), 32'(vecs[i].e_crv));
         chk($sformatf("row%0d aux_rvalid", i), 32'(aux_if.rvalid), 32'(vecs[i].e_arv));
         chk($sformatf("row%0d bram_we", i), 32'(bram_we), 32'(vecs[i].e_bwe));
         if (vecs[i].rst)
            chk($sformatf("row%0d bram_addr", i), 32'(bram_addr), 32'(e_addr));
         if (vecs[i].e_crv)
            chk($sformatf("row%0d cpu_dout", i), 32'(cpu_if.dout), 32'(vecs[i].e_q));
         if (vecs[i].e_arv)
            chk($sformatf("row%0d aux_dout", i), 32'(aux_if.dout), 32'(vecs[i].e_q));
      end

      // Reset asserted while an aux read is in flight.
      @(negedge clk);
      drive(0, 0, 0, 0, 1, 0, 10'h002, 0);
      #2;
      chk("midrst aux_gnt before", 32'(aux_if.gnt), 32'd1);
      @(posedge clk);
      #1;
      drive(1, 1, 10'h012, 16'h5555, 1, 0, 10'h002, 0);
      #1;
      chk("midrst aux_rvalid in flight", 32'(aux_if.rvalid), 32'd1);
      rst = 1'b0;
      #1;
      chk("midrst aux_rvalid", 32'(aux_if.rvalid), 32'd0);
      chk("midrst cpu_rvalid", 32'(cpu_if.rvalid), 32'd0);
      chk("midrst cpu_gnt", 32'(cpu_if.gnt), 32'd0);
      chk("midrst aux_gnt", 32'(aux_if.gnt), 32'd0);
      chk("midrst bram_we", 32'(bram_we), 32'd0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #2;
         chk($sformatf("post-rst%0d aux_rvalid", k), 32'(aux_if.rvalid), 32'd0);
         chk($sformatf("post-rst%0d cpu_rvalid", k), 32'(cpu_if.rvalid), 32'd0);
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
